alu_wide_seq: RTL and testbench

Multi-byte arithmetic sequencer for the Gumnut core's 8-bit ALU datapath. It accepts an N-byte add/subtract request, feeds it to the 8-bit `alua` unit one byte per cycle from LSB to MSB, and chains each byte's carry/borrow into the next. It collects the byte results into a full-width result with carry, overflow and zero flags, and signals completion with a one-cycle done pulse. It sits directly upstream of `alua`, driving its operand, select and carry-in inputs, and consumes `alua`'s result, carry-out and overflow outputs.

---
 rtl/alu_wide_seq.sv | 133 +++++++++++++
 tb/tb_alu_wide_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wide_seq.sv
// Multi-byte add/subtract sequencer that drives an 8-bit alua one byte per cycle,
// LSB first, chaining carry/borrow and assembling a full-width result with flags.
module alu_wide_seq #(
  parameter int         NBYTES   = 2,
  parameter logic [1:0] SEL_ADD  = 2'b00,
  parameter logic [1:0] SEL_ADDC = 2'b01,
  parameter logic [1:0] SEL_SUB  = 2'b10,
  parameter logic [1:0] SEL_SUBC = 2'b11,
  localparam int        W        = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         v_out,
  output logic         z_out,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [1:0]   alu_sel,
  output logic         alu_cin,
  input  logic [7:0]   alu_out,
  input  logic         alu_cout,
  input  logic         alu_vout
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
  // Every byte except the MSB; empty for a single-byte configuration.
  localparam logic [W-1:0] LOW_MASK = {W{1'b1}} >> 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [1:0]      r_op;
  logic            r_cin;
  logic            r_carry;
  logic [W-1:0]    r_result;
  logic            r_c;
  logic            r_v;
  logic            r_z;

  logic            w_is_sub;
  logic            w_use_cin;
  logic            w_low_zero;

  assign w_is_sub   = (r_op == SEL_SUB) || (r_op == SEL_SUBC);
  assign w_use_cin  = (r_op == SEL_ADDC) || (r_op == SEL_SUBC);
  assign w_low_zero = ((r_result & LOW_MASK) == '0);

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign c_out  = r_c;
  assign v_out  = r_v;
  assign z_out  = r_z;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    alu_cin = 1'b0;
    if (r_state == ST_RUN) begin
      alu_a = r_a[{r_idx, 3'b000} +: 8];
      alu_b = r_b[{r_idx, 3'b000} +: 8];
      if (r_idx == '0) begin
        alu_sel = r_op;
        alu_cin = w_use_cin ? r_cin : 1'b0;
      end else begin
        // Upper bytes always chain the previous byte's carry/borrow.
        alu_sel = w_is_sub ? SEL_SUBC : SEL_ADDC;
        alu_cin = r_carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cin    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cin   <= cin;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result[{r_idx, 3'b000} +: 8] <= alu_out;
          r_carry <= alu_cout;
          if (r_idx == LAST_IDX) begin
            r_c     <= alu_cout;
            r_v     <= alu_vout;
            r_z     <= w_low_zero && (alu_out == 8'h00);
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq: three instances (1, 2 and 4 bytes) against a full-width
// arithmetic reference model, plus hand-computed directed vectors.
module tb_alu_wide_seq;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDC = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_SUBC = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_k [3] = '{1'b0, 1'b0, 1'b0};
  logic [1:0]  op  = '0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        cin = 1'b0;

  logic        busy_k [3];
  logic        done_k [3];
  logic        c_k    [3];
  logic        v_k    [3];
  logic        z_k    [3];
  logic [7:0]  aa_k   [3];
  logic [7:0]  ab_k   [3];
  logic [1:0]  sel_k  [3];
  logic        ci_k   [3];
  logic [7:0]  ao_k   [3];
  logic        aco_k  [3];
  logic        avo_k  [3];
  logic [31:0] res_k  [3];
  logic [7:0]  res1;
  logic [15:0] res2;
  logic [31:0] res4;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int          m_ph  [3] = '{0, 0, 0};
  logic [31:0] m_a   [3];
  logic [31:0] m_b   [3];
  logic [1:0]  m_op  [3];
  logic        m_cin [3];
  logic [31:0] m_res [3];
  logic        m_c   [3];
  logic        m_v   [3];
  logic        m_z   [3];

  logic [1:0] sel_h [16];
  logic       cin_h [16];

  initial forever #5 clk = ~clk;

  // Bit-accurate 8-bit alua: carry-out is a borrow flag for subtraction.
  function automatic logic [9:0] alua(input logic [7:0] x, input logic [7:0] y,
                                      input logic [1:0] s, input logic ci);
    logic [8:0] t;
    logic       ce;
    logic       vv;
    ce = s[0] ? ci : 1'b0;
    if (!s[1]) begin
      t  = {1'b0, x} + {1'b0, y} + {8'b0, ce};
      vv = (x[7] == y[7]) && (t[7] != x[7]);
    end else begin
      t  = {1'b0, x} - {1'b0, y} - {8'b0, ce};
      vv = (x[7] != y[7]) && (t[7] != x[7]);
    end
    return {vv, t[8], t[7:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_alua
    assign {avo_k[g], aco_k[g], ao_k[g]} = alua(aa_k[g], ab_k[g], sel_k[g], ci_k[g]);
  end

  assign res_k[0] = {24'h0, res1};
  assign res_k[1] = {16'h0, res2};
  assign res_k[2] = res4;

  alu_wide_seq #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_k[0]), .op(op), .a(a32[7:0]), .b(b32[7:0]), .cin(cin),
    .busy(busy_k[0]), .done(done_k[0]), .result(res1), .c_out(c_k[0]), .v_out(v_k[0]),
    .z_out(z_k[0]), .alu_a(aa_k[0]), .alu_b(ab_k[0]), .alu_sel(sel_k[0]), .alu_cin(ci_k[0]),
    .alu_out(ao_k[0]), .alu_cout(aco_k[0]), .alu_vout(avo_k[0]));

  alu_wide_seq #(.NBYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_k[1]), .op(op), .a(a32[15:0]), .b(b32[15:0]), .cin(cin),
    .busy(busy_k[1]), .done(done_k[1]), .result(res2), .c_out(c_k[1]), .v_out(v_k[1]),
    .z_out(z_k[1]), .alu_a(aa_k[1]), .alu_b(ab_k[1]), .alu_sel(sel_k[1]), .alu_cin(ci_k[1]),
    .alu_out(ao_k[1]), .alu_cout(aco_k[1]), .alu_vout(avo_k[1]));

  alu_wide_seq #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_k[2]), .op(op), .a(a32), .b(b32), .cin(cin),
    .busy(busy_k[2]), .done(done_k[2]), .result(res4), .c_out(c_k[2]), .v_out(v_k[2]),
    .z_out(z_k[2]), .alu_a(aa_k[2]), .alu_b(ab_k[2]), .alu_sel(sel_k[2]), .alu_cin(ci_k[2]),
    .alu_out(ao_k[2]), .alu_cout(aco_k[2]), .alu_vout(avo_k[2]));

  function automatic int nb_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  // Whole-width reference: {v, c, result}.
  function automatic logic [33:0] ref_op(input int nb, input logic [1:0] o,
                                         input logic [31:0] x, input logic [31:0] y,
                                         input logic ci);
    longint unsigned m, xm, ym, ce, s, r;
    logic c, v, xs, ys, rs;
    int w;
    w  = 8 * nb;
    m  = (64'd1 << w) - 64'd1;
    xm = {32'h0, x} & m;
    ym = {32'h0, y} & m;
    ce = (o[0] && ci) ? 64'd1 : 64'd0;
    if (!o[1]) begin
      s = xm + ym + ce;
      r = s & m;
      c = (s >> w) != 0;
    end else begin
      r = (xm - ym - ce) & m;
      c = xm < (ym + ce);
    end
    xs = ((xm >> (w - 1)) & 64'd1) != 0;
    ys = ((ym >> (w - 1)) & 64'd1) != 0;
    rs = ((r  >> (w - 1)) & 64'd1) != 0;
    v  = o[1] ? ((xs != ys) && (rs != xs)) : ((xs == ys) && (rs != xs));
    return {v, c, r[31:0]};
  endfunction

  // Carry (add) or borrow (sub) flowing into byte i of the whole-width operation.
  function automatic logic carry_into(input int i, input logic [1:0] o,
                                      input logic [31:0] x, input logic [31:0] y,
                                      input logic ci);
    longint unsigned m, xm, ym, ce;
    m  = (64'd1 << (8 * i)) - 64'd1;
    xm = {32'h0, x} & m;
    ym = {32'h0, y} & m;
    ce = (o[0] && ci) ? 64'd1 : 64'd0;
    if (!o[1]) return ((xm + ym + ce) >> (8 * i)) != 0;
    return xm < (ym + ce);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [nbytes=%0d] t=%0t got %h want %h", nm, nb_of(k), $time, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      int nb, ph, i;
      nb = nb_of(k);
      ph = m_ph[k];
      chk("busy", k, 32'(busy_k[k]), 32'(ph != 0));
      chk("done", k, 32'(done_k[k]), 32'(ph == nb + 1));
      if (ph >= 1 && ph <= nb) begin
        i = ph - 1;
        chk("alu_a", k, 32'(aa_k[k]), (m_a[k] >> (8 * i)) & 32'hFF);
        chk("alu_b", k, 32'(ab_k[k]), (m_b[k] >> (8 * i)) & 32'hFF);
        chk("alu_sel", k, 32'(sel_k[k]), (i == 0) ? 32'(m_op[k]) : 32'({m_op[k][1], 1'b1}));
        chk("alu_cin", k, 32'(ci_k[k]), 32'(carry_into(i, m_op[k], m_a[k], m_b[k], m_cin[k])));
      end else begin
        chk("alu_idle", k, {aa_k[k], ab_k[k], 13'h0, sel_k[k], ci_k[k]}, 32'h0);
      end
      if (ph == 0 || ph == nb + 1) begin
        chk("result", k, res_k[k], m_res[k]);
        chk("flags", k, {29'h0, c_k[k], v_k[k], z_k[k]}, {29'h0, m_c[k], m_v[k], m_z[k]});
      end
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int nb;
      nb = nb_of(k);
      if (rst) begin
        m_ph[k] = 0; m_res[k] = '0; m_c[k] = 1'b0; m_v[k] = 1'b0; m_z[k] = 1'b0;
      end else if (m_ph[k] == 0) begin
        if (start_k[k]) begin
          m_a[k] = a32; m_b[k] = b32; m_op[k] = op; m_cin[k] = cin; m_ph[k] = 1;
        end
      end else if (m_ph[k] <= nb) begin
        if (m_ph[k] == nb) begin
          {m_v[k], m_c[k], m_res[k]} = ref_op(nb, m_op[k], m_a[k], m_b[k], m_cin[k]);
          m_z[k] = (m_res[k] == 32'h0);
        end
        m_ph[k] = m_ph[k] + 1;
      end else begin
        m_ph[k] = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic run_op(input int k, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic ci);
    int lat;
    start_k[k] = 1'b1; op = o; a32 = x; b32 = y; cin = ci;
    tick();
    start_k[k] = 1'b0;
    op = 2'($urandom); a32 = $urandom; b32 = $urandom; cin = 1'($urandom);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      sel_h[c] = sel_k[k];
      cin_h[c] = ci_k[k];
      if (done_k[k]) begin
        lat = c;
        break;
      end
      tick();
    end
    chk("done_latency", k, 32'(lat), 32'(nb_of(k) + 1));
    tick();
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_busy", 1, 32'(busy_k[1]), 32'h0);
    chk("rst_result", 1, res_k[1], 32'h0);
    chk("rst_flags", 1, {29'h0, c_k[1], v_k[1], z_k[1]}, 32'h0);
    rst = 1'b0;
    tick();

    run_op(1, OP_ADD, 32'h12FF, 32'h0001, 1'b0);
    chk("add_sel_c1", 1, 32'(sel_h[1]), 32'h0);
    chk("add_sel_c2", 1, 32'(sel_h[2]), 32'h1);
    chk("add_cin_c2", 1, 32'(cin_h[2]), 32'h1);
    chk("add_result", 1, res_k[1], 32'h1300);
    chk("add_cvz", 1, {29'h0, c_k[1], v_k[1], z_k[1]}, 32'h0);

    run_op(1, OP_ADD, 32'hFFFF, 32'h0001, 1'b1);
    chk("wrap_result", 1, res_k[1], 32'h0000);
    chk("wrap_cvz", 1, {29'h0, c_k[1], v_k[1], z_k[1]}, 32'h5);

    run_op(1, OP_ADDC, 32'h7FFF, 32'h0000, 1'b1);
    chk("addc_cin_c1", 1, 32'(cin_h[1]), 32'h1);
    chk("addc_result", 1, res_k[1], 32'h8000);
    chk("addc_cvz", 1, {29'h0, c_k[1], v_k[1], z_k[1]}, 32'h2);

    run_op(1, OP_SUB, 32'h0100, 32'h0001, 1'b1);
    chk("sub_sel_c1", 1, {30'h0, sel_h[1]}, 32'h2);
    chk("sub_cin_c1", 1, 32'(cin_h[1]), 32'h0);
    chk("sub_sel_c2", 1, {30'h0, sel_h[2]}, 32'h3);
    chk("sub_cin_c2", 1, 32'(cin_h[2]), 32'h1);
    chk("sub_result", 1, res_k[1], 32'h00FF);
    chk("sub_z", 1, 32'(z_k[1]), 32'h0);

    run_op(0, OP_ADDC, 32'h00FF, 32'h0000, 1'b1);
    chk("nb1_addc_result", 0, res_k[0], 32'h00);
    chk("nb1_addc_cvz", 0, {29'h0, c_k[0], v_k[0], z_k[0]}, 32'h5);
    run_op(2, OP_SUBC, 32'h0, 32'h0, 1'b1);
    chk("nb4_subc_result", 2, res_k[2], 32'hFFFF_FFFF);
    chk("nb4_subc_cvz", 2, {29'h0, c_k[2], v_k[2], z_k[2]}, 32'h4);

    // start pulses during RUN and DONE must be ignored.
    start_k[1] = 1'b1; op = OP_ADD; a32 = 32'h0102; b32 = 32'h0304; cin = 1'b0;
    tick();
    op = OP_SUB; a32 = 32'hFFFF; b32 = 32'h1234;
    tick();
    start_k[1] = 1'b0;
    tick();
    chk("ctl_done", 1, 32'(done_k[1]), 32'h1);
    start_k[1] = 1'b1; a32 = 32'h5; b32 = 32'h5;
    tick();
    start_k[1] = 1'b0;
    chk("ctl_idle_after_done", 1, 32'(busy_k[1]), 32'h0);
    tick();
    chk("ctl_still_idle", 1, 32'(busy_k[1]), 32'h0);
    chk("ctl_result", 1, res_k[1], 32'h0406);

    // Reset in the second RUN cycle aborts the operation.
    start_k[1] = 1'b1; op = OP_ADD; a32 = 32'h1111; b32 = 32'h1111;
    tick();
    start_k[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 1, 32'(busy_k[1]), 32'h0);
    chk("abort_done", 1, 32'(done_k[1]), 32'h0);
    chk("abort_result", 1, res_k[1], 32'h0);
    tick();
    chk("abort_no_done", 1, 32'(done_k[1]), 32'h0);

    for (int n = 0; n < 500; n++) run_op(0, 2'($urandom), $urandom, $urandom, 1'($urandom));
    for (int n = 0; n < 500; n++) run_op(2, 2'($urandom), $urandom, $urandom, 1'($urandom));
    for (int n = 0; n < 100; n++) run_op(1, 2'($urandom), $urandom, $urandom, 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
